// File: rtl/gdlinebuf_pkg.sv
// Shared types and helpers for the gdlinebuf ping-pong sprite line buffer.
package gdlinebuf_pkg;

  // Upper bounds on address/data width carried by the write stage record.
  localparam int GDLB_AW_MAX = 16;
  localparam int GDLB_DW_MAX = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } gdlb_state_t;

  // One in-flight draw write: valid, target bank tag, address and pixel.
  typedef struct packed {
    logic                   vld;
    logic                   bank;
    logic [GDLB_AW_MAX-1:0] addr;
    logic [GDLB_DW_MAX-1:0] data;
  } wr_stage_t;

  // True when the low tw bits of data equal the transparent key.
  function automatic logic is_transp(input logic [GDLB_DW_MAX-1:0] data,
                                     input int unsigned            tw,
                                     input logic [GDLB_DW_MAX-1:0] transp);
    logic [GDLB_DW_MAX-1:0] mask;
    mask = (GDLB_DW_MAX'(1) << tw) - GDLB_DW_MAX'(1);
    return ((data ^ transp) & mask) == '0;
  endfunction

endpackage

// File: rtl/gdlb_bank.sv
// One line-buffer bank: simple dual-port RAM, one read and one write port,
// registered read returning the word as it was before a same-edge write.
module gdlb_bank #(
  parameter int AW = 10,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port and read-old-data read port; rdata holds while re is low.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gdlinebuf.sv
// Ping-pong sprite line buffer: draw bank written by the sprite engine,
// display bank read and cleared by the video stage, swapped on SWAP.
// Optional macro GDLINEBUF_PRIO_EN: first-drawn pixel wins over later ones.
module gdlinebuf
  import gdlinebuf_pkg::*;
#(
  parameter int            AW     = 10,
  parameter int            DW     = 9,
  parameter int            TW     = 4,
  parameter logic [TW-1:0] TRANSP = '0,
  parameter logic [DW-1:0] CLRV   = '0
) (
  input  logic          CL,
  input  logic          RST_N,
  input  logic          SWAP,
  input  logic [AW-1:0] RAD,
  input  logic          RE,
  output logic [DW-1:0] RDO,
  input  logic [AW-1:0] WAD,
  input  logic          WE,
  input  logic [DW-1:0] WDI,
  output logic          BUSY,
  output logic          BANK
);

  localparam logic [GDLB_DW_MAX-1:0] TRANSP_X = GDLB_DW_MAX'(TRANSP);

  gdlb_state_t   state;
  logic [AW-1:0] sweep;
  logic          bank_q;
  logic          run, swap_go, bank_eff, disp_eff, re_go, we_go;

  wr_stage_t     wr_p1;
  logic          commit_p1;
  logic          unused_p1;

  logic          rd_vld_p1, rd_bank_p1;
  logic [DW-1:0] rdo_hold;

  logic          bank_we [2];
  logic [AW-1:0] bank_wa [2];
  logic [DW-1:0] bank_wd [2];
  logic          bank_re [2];
  logic [AW-1:0] bank_ra [2];
  logic [DW-1:0] bank_rd [2];

  // A swap takes effect on the edge it is sampled, so role selection for
  // that same edge already uses the toggled bank.
  assign run      = (state == ST_RUN);
  assign swap_go  = run & SWAP;
  assign re_go    = run & RE;
  assign we_go    = run & WE;
  assign bank_eff = bank_q ^ swap_go;
  assign disp_eff = ~bank_eff;
  assign BANK     = bank_q;

  // Clear-sweep FSM: INIT walks every address once, then RUN forever.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_INIT;
      sweep <= '0;
      BUSY  <= 1'b1;
    end else if (state == ST_INIT) begin
      sweep <= sweep + AW'(1);
      if (sweep == '1) begin
        state <= ST_RUN;
        BUSY  <= 1'b0;
      end
    end
  end

  // Draw bank index toggles on every accepted line strobe.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) bank_q <= 1'b0;
    else if (swap_go) bank_q <= ~bank_q;
  end

  // Write stage 1: capture the request and its bank tag; the RAM read of
  // the existing word is issued on the same edge.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      wr_p1.vld <= 1'b0;
    end else begin
      wr_p1.vld  <= we_go;
      wr_p1.bank <= bank_eff;
      wr_p1.addr <= GDLB_AW_MAX'(WAD);
      wr_p1.data <= GDLB_DW_MAX'(WDI);
    end
  end

  assign unused_p1 = ^{wr_p1.addr, wr_p1.data};

`ifdef GDLINEBUF_PRIO_EN
  logic          fwd_p1;
  logic [DW-1:0] fwd_data_p1;
  logic [DW-1:0] exist_p1;

  // The stage-1 read misses the write committing on the same edge, so
  // remember that write when it hits the same bank and address.
  always_ff @(posedge CL) begin
    fwd_p1      <= commit_p1 && (wr_p1.bank == bank_eff) &&
                   (wr_p1.addr == GDLB_AW_MAX'(WAD));
    fwd_data_p1 <= wr_p1.data[DW-1:0];
  end

  assign exist_p1  = fwd_p1 ? fwd_data_p1 : bank_rd[wr_p1.bank];
  assign commit_p1 = wr_p1.vld && !is_transp(wr_p1.data, TW, TRANSP_X) &&
                     is_transp(GDLB_DW_MAX'(exist_p1), TW, TRANSP_X);
`else
  assign commit_p1 = wr_p1.vld && !is_transp(wr_p1.data, TW, TRANSP_X);
`endif

  // Bank port steering: sweep in INIT; in RUN the stage-2 commit owns the
  // write port of its tagged bank and a colliding clear-on-read is dropped.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      bank_we[k] = 1'b0;
      bank_wa[k] = '0;
      bank_wd[k] = CLRV;
      bank_re[k] = 1'b0;
      bank_ra[k] = '0;
      if (!run) begin
        bank_we[k] = 1'b1;
        bank_wa[k] = sweep;
      end else begin
        if (commit_p1 && (wr_p1.bank == 1'(k))) begin
          bank_we[k] = 1'b1;
          bank_wa[k] = wr_p1.addr[AW-1:0];
          bank_wd[k] = wr_p1.data[DW-1:0];
        end else if (re_go && (disp_eff == 1'(k))) begin
          bank_we[k] = 1'b1;
          bank_wa[k] = RAD;
        end
        if (disp_eff == 1'(k)) begin
          bank_re[k] = re_go;
          bank_ra[k] = RAD;
        end else begin
          bank_re[k] = we_go;
          bank_ra[k] = WAD;
        end
      end
    end
  end

  gdlb_bank #(.AW(AW), .DW(DW)) u_bank0 (
    .clk  (CL),
    .re   (bank_re[0]),
    .raddr(bank_ra[0]),
    .rdata(bank_rd[0]),
    .we   (bank_we[0]),
    .waddr(bank_wa[0]),
    .wdata(bank_wd[0])
  );

  gdlb_bank #(.AW(AW), .DW(DW)) u_bank1 (
    .clk  (CL),
    .re   (bank_re[1]),
    .raddr(bank_ra[1]),
    .rdata(bank_rd[1]),
    .we   (bank_we[1]),
    .waddr(bank_wa[1]),
    .wdata(bank_wd[1])
  );

  // Display read stage 1: remember which bank answered; RDO holds otherwise.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      rd_vld_p1  <= 1'b0;
      rd_bank_p1 <= 1'b0;
      rdo_hold   <= '0;
    end else begin
      rd_vld_p1  <= re_go;
      rd_bank_p1 <= disp_eff;
      rdo_hold   <= RDO;
    end
  end

  assign RDO = rd_vld_p1 ? bank_rd[rd_bank_p1] : rdo_hold;

endmodule

// File: tb/tb_gdlinebuf.sv
// Directed testbench for gdlinebuf (default parameters AW=10, DW=9, TW=4,
// TRANSP=0, CLRV=0); expected values are hand-computed constants.
module tb_gdlinebuf;

  localparam int AW = 10;
  localparam int DW = 9;

  logic          CL    = 1'b0;
  logic          RST_N = 1'b0;
  logic          SWAP  = 1'b0;
  logic [AW-1:0] RAD   = '0;
  logic          RE    = 1'b0;
  logic [DW-1:0] RDO;
  logic [AW-1:0] WAD   = '0;
  logic          WE    = 1'b0;
  logic [DW-1:0] WDI   = '0;
  logic          BUSY;
  logic          BANK;

  int n_chk = 0;
  int n_err = 0;

  always #5 CL = ~CL;

  gdlinebuf dut (
    .CL   (CL),
    .RST_N(RST_N),
    .SWAP (SWAP),
    .RAD  (RAD),
    .RE   (RE),
    .RDO  (RDO),
    .WAD  (WAD),
    .WE   (WE),
    .WDI  (WDI),
    .BUSY (BUSY),
    .BANK (BANK)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WE = 1'b1; WAD = a; WDI = d;
    tick();
    WE = 1'b0;
  endtask

  task automatic do_swap();
    SWAP = 1'b1;
    tick();
    SWAP = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    RE = 1'b1; RAD = a;
    tick();
    RE = 1'b0;
    chk(tag, 32'(RDO), 32'(exp));
  endtask

  task automatic wait_sweep(input string tag);
    int cnt;
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 3000) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd1024);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] prio_exp;

    #12;
    chk("rst_rdo",  32'(RDO),  32'h0);
    chk("rst_busy", 32'(BUSY), 32'h1);
    chk("rst_bank", 32'(BANK), 32'h0);

    // Release reset; SWAP and WE held high during the sweep must be ignored.
    @(posedge CL); #1;
    RST_N = 1'b1;
    SWAP = 1'b1; WE = 1'b1; WAD = '0; WDI = 9'h1FF;
    wait_sweep("busy_cycles");
    SWAP = 1'b0; WE = 1'b0;
    chk("init_bank", 32'(BANK), 32'h0);
    chk("init_busy", 32'(BUSY), 32'h0);

    // Both banks must read back as cleared.
    for (int a = 0; a < 1024; a++) rd("sweep_disp1", AW'(a), 9'h000);
    do_swap();
    chk("sweep_bank", 32'(BANK), 32'h1);
    for (int a = 0; a < 1024; a++) rd("sweep_disp0", AW'(a), 9'h000);

    // Basic write, swap, read, clear-on-read.
    wr(10'd5, 9'h1A3);
    do_swap();
    chk("t2_bank", 32'(BANK), 32'h0);
    rd("t2_rd5",  10'd5, 9'h1A3);
    rd("t2_clr5", 10'd5, 9'h000);

    // Transparent pixel over an existing pixel is skipped.
    wr(10'd7, 9'h0A5);
    wr(10'd7, 9'h120);
    do_swap();
    rd("t3_rd7", 10'd7, 9'h0A5);
    tick();
    chk("t3_hold", 32'(RDO), 32'h0A5);
    rd("t3_clr7", 10'd7, 9'h000);

    // Back-to-back writes to one address.
`ifdef GDLINEBUF_PRIO_EN
    prio_exp = 9'h011;
`else
    prio_exp = 9'h022;
`endif
    wr(10'd9, 9'h011);
    wr(10'd9, 9'h022);
    do_swap();
    rd("t4_prio9", 10'd9, prio_exp);

    // Swap boundary, different address: the clear of RAD=6 is dropped.
    wr(10'd6, 9'h066);
    tick();
    WE = 1'b1; WAD = 10'd3; WDI = 9'h0C1;
    tick();
    WE = 1'b0;
    SWAP = 1'b1; RE = 1'b1; RAD = 10'd6;
    tick();
    SWAP = 1'b0; RE = 1'b0;
    chk("drop_rdo",  32'(RDO),  32'h066);
    chk("drop_bank", 32'(BANK), 32'h1);
    rd("drop_keep6", 10'd6, 9'h066);
    rd("drop_new3",  10'd3, 9'h0C1);
    rd("drop_clr3",  10'd3, 9'h000);
    rd("drop_clr6",  10'd6, 9'h000);

    // Swap boundary, same address: old value read, new pixel kept.
    WE = 1'b1; WAD = 10'd4; WDI = 9'h0D2;
    tick();
    WE = 1'b0;
    SWAP = 1'b1; RE = 1'b1; RAD = 10'd4;
    tick();
    SWAP = 1'b0; RE = 1'b0;
    chk("same_rdo",  32'(RDO),  32'h000);
    chk("same_bank", 32'(BANK), 32'h0);
    rd("same_new4", 10'd4, 9'h0D2);
    rd("same_clr4", 10'd4, 9'h000);

    // Consecutive swaps toggle every cycle.
    SWAP = 1'b1;
    tick();
    chk("dswap_1", 32'(BANK), 32'h1);
    tick();
    chk("dswap_2", 32'(BANK), 32'h0);
    SWAP = 1'b0;

    // Simultaneous read and write to different banks.
    WE = 1'b1; WAD = 10'd8; WDI = 9'h0E3;
    RE = 1'b1; RAD = 10'd8;
    tick();
    WE = 1'b0; RE = 1'b0;
    chk("par_rdo", 32'(RDO), 32'h000);
    do_swap();
    chk("par_bank", 32'(BANK), 32'h1);
    rd("par_rd8", 10'd8, 9'h0E3);

    // Reset mid-line with a write in flight.
    WE = 1'b1; WAD = 10'd10; WDI = 9'h0F7;
    tick();
    WE = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("mrst_rdo",  32'(RDO),  32'h0);
    chk("mrst_bank", 32'(BANK), 32'h0);
    chk("mrst_busy", 32'(BUSY), 32'h1);
    @(posedge CL);
    @(posedge CL); #1;
    RST_N = 1'b1;
    wait_sweep("mrst_busy_cycles");
    chk("mrst_bank2", 32'(BANK), 32'h0);
    rd("mrst_rd10_b1", 10'd10, 9'h000);
    rd("mrst_rd8_b1",  10'd8,  9'h000);
    do_swap();
    rd("mrst_rd10_b0", 10'd10, 9'h000);
    rd("mrst_rd8_b0",  10'd8,  9'h000);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
